avmm_burst_arbiter: RTL and testbench

Two-requester, round-robin Avalon-MM burst arbiter that shares the single HPS bridge port of `soc_system` between fabric masters (HDMI frame reader and pattern/DMA writer). It locks the grant for the full length of a write burst and pipelines read bursts through a tag FIFO, so read data is routed to the correct requester while the other requester issues commands. It sits in `system_top_level` between the fabric masters and the `hps_bridge_*` signals.

---
 rtl/avmm_burst_arbiter.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_avmm_burst_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : avmm_burst_arbiter
//  Purpose  : Two-requester round-robin Avalon-MM burst arbiter in front of a
//             single shared master port. Write bursts lock the grant until
//             the final beat is accepted. Read bursts are released as soon
//             as the command is accepted. A tag FIFO records the owner and
//             length of each read burst so that read beats coming back are
//             routed to the requester that issued them.
//  Ports    : clk, reset           - clock, asynchronous active-high reset
//             m0_* / m1_*          - requester Avalon-MM slave side
//             av_*                 - shared Avalon-MM master side
//             rd_orphan            - sticky: read beat arrived with no tag
//  Revision : 1.0 - initial release
// ============================================================================
module avmm_burst_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_W   = 8,
    parameter int TAG_DEPTH = 4     // power of two, at least 2
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [BURST_W-1:0]    m0_burstcount,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [BURST_W-1:0]    m1_burstcount,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     av_address,
    output logic                  av_read,
    output logic                  av_write,
    output logic [BURST_W-1:0]    av_burstcount,
    output logic [DATA_W-1:0]     av_writedata,
    output logic [DATA_W/8-1:0]   av_byteenable,
    input  logic                  av_waitrequest,
    input  logic [DATA_W-1:0]     av_readdata,
    input  logic                  av_readdatavalid,

    output logic                  rd_orphan
);

    localparam int c_PTR_W = $clog2(TAG_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_GRANT_RD = 2'd1;
    localparam logic [1:0] c_GRANT_WR = 2'd2;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_own;
    logic                r_pri;
    logic [ADDR_W-1:0]   r_addr;
    logic [BURST_W-1:0]  r_bc;
    logic [BURST_W-1:0]  r_beats;

    logic                r_tag_own [TAG_DEPTH];
    logic [BURST_W-1:0]  r_tag_bc  [TAG_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [BURST_W-1:0]  r_ret_cnt;
    logic                r_orphan;

    logic                w_full;
    logic                w_empty;
    logic                w_elig0;
    logic                w_elig1;
    logic                w_grant_any;
    logic                w_win;
    logic                w_win_wr;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [BURST_W-1:0]  w_win_bc_raw;
    logic [BURST_W-1:0]  w_win_bc;
    logic                w_own_read;
    logic                w_own_write;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic                w_push;
    logic                w_beat;
    logic                w_last;
    logic                w_pop;
    logic                w_head_own;
    logic [BURST_W-1:0]  w_head_bc;

    // ------------------------------------------------------------------
    // Arbitration. A read is only a candidate while the registered full
    // flag is clear; a pop landing on the same edge does not count, which
    // keeps the full check off the return-path timing.
    // ------------------------------------------------------------------
    assign w_full  = (r_count == c_CNT_W'(TAG_DEPTH));
    assign w_empty = (r_count == '0);

    assign w_elig0 = m0_write | (m0_read & ~w_full);
    assign w_elig1 = m1_write | (m1_read & ~w_full);

    always_comb begin
        w_grant_any = 1'b0;
        w_win       = r_pri;
        if (w_elig0 && w_elig1) begin
            w_grant_any = 1'b1;
            w_win       = r_pri;
        end else if (w_elig0) begin
            w_grant_any = 1'b1;
            w_win       = 1'b0;
        end else if (w_elig1) begin
            w_grant_any = 1'b1;
            w_win       = 1'b1;
        end
    end

    assign w_win_wr     = w_win ? m1_write      : m0_write;
    assign w_win_addr   = w_win ? m1_address    : m0_address;
    assign w_win_bc_raw = w_win ? m1_burstcount : m0_burstcount;
    // A zero burstcount is illegal; carry it through as a single beat.
    assign w_win_bc     = (w_win_bc_raw == '0) ? BURST_W'(1) : w_win_bc_raw;

    assign w_own_read  = r_own ? m1_read  : m0_read;
    assign w_own_write = r_own ? m1_write : m0_write;

    assign w_rd_acc = (r_state == c_GRANT_RD) & w_own_read  & ~av_waitrequest;
    assign w_wr_acc = (r_state == c_GRANT_WR) & w_own_write & ~av_waitrequest;

    // ------------------------------------------------------------------
    // Grant FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant FSM: next state. A write grant is held until the beat counter
    // runs out, even if the owner drops write mid-burst.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant_any) begin
                    w_state_nxt = w_win_wr ? c_GRANT_WR : c_GRANT_RD;
                end
            end
            c_GRANT_RD: begin
                if (w_rd_acc) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_GRANT_WR: begin
                if (w_wr_acc && (r_beats == BURST_W'(1))) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Grant FSM: outputs
    always_comb begin
        av_read        = 1'b0;
        av_write       = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (r_state)
            c_GRANT_RD: begin
                av_read = w_own_read;
                if (r_own) begin
                    m1_waitrequest = av_waitrequest;
                end else begin
                    m0_waitrequest = av_waitrequest;
                end
            end
            c_GRANT_WR: begin
                av_write = w_own_write;
                if (r_own) begin
                    m1_waitrequest = av_waitrequest;
                end else begin
                    m0_waitrequest = av_waitrequest;
                end
            end
            default: begin
                av_read  = 1'b0;
                av_write = 1'b0;
            end
        endcase
    end

    // Owner, round-robin pointer and first-beat command capture. Address
    // and burstcount stay frozen for the whole grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_own   <= 1'b0;
            r_pri   <= 1'b0;
            r_addr  <= '0;
            r_bc    <= '0;
            r_beats <= '0;
        end else if ((r_state == c_IDLE) && w_grant_any) begin
            r_own   <= w_win;
            r_pri   <= ~w_win;
            r_addr  <= w_win_addr;
            r_bc    <= w_win_bc;
            r_beats <= w_win_wr ? w_win_bc : '0;
        end else if (w_wr_acc) begin
            r_beats <= r_beats - BURST_W'(1);
        end
    end

    assign av_address    = r_addr;
    assign av_burstcount = r_bc;
    assign av_writedata  = r_own ? m1_writedata  : m0_writedata;
    assign av_byteenable = r_own ? m1_byteenable : m0_byteenable;

    // ------------------------------------------------------------------
    // Tag FIFO and read return path. The head entry's beats are counted up
    // from zero so no per-entry load of a down-counter is needed.
    // ------------------------------------------------------------------
    assign w_push     = w_rd_acc;
    assign w_head_own = r_tag_own[r_rd_ptr];
    assign w_head_bc  = r_tag_bc[r_rd_ptr];
    assign w_beat     = av_readdatavalid & ~w_empty;
    assign w_last     = (r_ret_cnt == (w_head_bc - BURST_W'(1)));
    assign w_pop      = w_beat & w_last;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_own[r_wr_ptr] <= r_own;
            r_tag_bc[r_wr_ptr]  <= r_bc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ret_cnt <= '0;
            r_orphan  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_beat) begin
                r_ret_cnt <= w_last ? '0 : (r_ret_cnt + BURST_W'(1));
            end
            // Beats with no tag (e.g. still in flight across a reset) are
            // dropped and flagged.
            if (av_readdatavalid && w_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

    assign m0_readdata      = av_readdata;
    assign m1_readdata      = av_readdata;
    assign m0_readdatavalid = w_beat & ~w_head_own;
    assign m1_readdatavalid = w_beat &  w_head_own;
    assign rd_orphan        = r_orphan;

endmodule
`default_nettype wire

// File: tb/tb_avmm_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_avmm_burst_arbiter
//  Purpose  : Scoreboard bench for avmm_burst_arbiter. Directed scenarios
//             push the commands and read beats they expect; a negedge
//             monitor pops and compares whenever the DUT presents an
//             accepted command or a read beat to a requester.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_avmm_burst_arbiter;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  bc;
        logic [3:0]  be;
        logic [31:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][31:0] m_addr;
    logic [1:0]       m_rd;
    logic [1:0]       m_wr;
    logic [1:0][7:0]  m_bc;
    logic [1:0][31:0] m_wd;
    logic [1:0][3:0]  m_be;
    wire  [1:0]       m_wait;
    wire  [1:0][31:0] m_rdata;
    wire  [1:0]       m_rdv;

    wire  [31:0] av_address;
    wire         av_read;
    wire         av_write;
    wire  [7:0]  av_burstcount;
    wire  [31:0] av_writedata;
    wire  [3:0]  av_byteenable;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic        av_readdatavalid;
    wire         rd_orphan;

    int total = 0;
    int bad   = 0;
    int ws_mode = 0;    // 0: always ready, 1: toggle, 2: stall

    cmd_t        exp_cmd[$];
    logic [31:0] exp_rd0[$];
    logic [31:0] exp_rd1[$];

    avmm_burst_arbiter #(
        .ADDR_W(32), .DATA_W(32), .BURST_W(8), .TAG_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_address(m_addr[0]), .m0_read(m_rd[0]), .m0_write(m_wr[0]),
        .m0_burstcount(m_bc[0]), .m0_writedata(m_wd[0]), .m0_byteenable(m_be[0]),
        .m0_waitrequest(m_wait[0]), .m0_readdata(m_rdata[0]), .m0_readdatavalid(m_rdv[0]),
        .m1_address(m_addr[1]), .m1_read(m_rd[1]), .m1_write(m_wr[1]),
        .m1_burstcount(m_bc[1]), .m1_writedata(m_wd[1]), .m1_byteenable(m_be[1]),
        .m1_waitrequest(m_wait[1]), .m1_readdata(m_rdata[1]), .m1_readdatavalid(m_rdv[1]),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_burstcount(av_burstcount), .av_writedata(av_writedata),
        .av_byteenable(av_byteenable), .av_waitrequest(av_waitrequest),
        .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
        .rd_orphan(rd_orphan)
    );

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic exp_r(input logic [31:0] a, input logic [7:0] bc);
        cmd_t c;
        c.wr = 1'b0; c.addr = a; c.bc = bc; c.be = 4'h0; c.data = 32'h0;
        exp_cmd.push_back(c);
    endtask

    task automatic exp_w(input logic [31:0] a, input logic [7:0] bc,
                         input logic [3:0] be, input logic [31:0] d);
        cmd_t c;
        c.wr = 1'b1; c.addr = a; c.bc = bc; c.be = be; c.data = d;
        exp_cmd.push_back(c);
    endtask

    // Requester read; caller is aligned just after a rising edge.
    task automatic mrd(input int n, input logic [31:0] a, input logic [7:0] bc);
        int t;
        t = 0;
        m_addr[n] = a; m_bc[n] = bc; m_rd[n] = 1'b1;
        while (1) begin
            @(negedge clk);
            if (!m_wait[n]) break;
            t++;
            if (t > 300) begin
                total++; bad++;
                $display("FAIL rd_timeout m%0d: waitrequest=1 required=0", n);
                break;
            end
        end
        @(posedge clk); #1;
        m_rd[n] = 1'b0;
    endtask

    task automatic mwr(input int n, input logic [31:0] a, input logic [7:0] bc,
                       input logic [3:0] be, input logic [31:0] d0);
        int t;
        int nb;
        nb = (bc == 8'd0) ? 1 : int'(bc);
        m_addr[n] = a; m_bc[n] = bc; m_be[n] = be; m_wd[n] = d0; m_wr[n] = 1'b1;
        for (int i = 0; i < nb; i++) begin
            t = 0;
            while (1) begin
                @(negedge clk);
                if (!m_wait[n]) break;
                t++;
                if (t > 300) begin
                    total++; bad++;
                    $display("FAIL wr_timeout m%0d: waitrequest=1 required=0", n);
                    break;
                end
            end
            @(posedge clk); #1;
            m_wd[n] = d0 + 32'(i + 1);
        end
        m_wr[n] = 1'b0;
    endtask

    task automatic ret(input int nb, input logic [31:0] d0);
        for (int i = 0; i < nb; i++) begin
            av_readdatavalid = 1'b1;
            av_readdata      = d0 + 32'(i);
            @(posedge clk); #1;
        end
        av_readdatavalid = 1'b0;
    endtask

    // Shared-slave waitrequest pattern
    initial begin
        av_waitrequest = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ws_mode)
                0:       av_waitrequest = 1'b0;
                1:       av_waitrequest = ~av_waitrequest;
                default: av_waitrequest = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        cmd_t got;
        cmd_t e;
        logic [31:0] er;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if ((av_read || av_write) && !av_waitrequest) begin
                    got.wr   = av_write;
                    got.addr = av_address;
                    got.bc   = av_burstcount;
                    got.be   = av_write ? av_byteenable : 4'h0;
                    got.data = av_write ? av_writedata  : 32'h0;
                    if (exp_cmd.size() == 0) begin
                        total++; bad++;
                        $display("FAIL cmd_unexpected: actual=%h required=none", got);
                    end else begin
                        e = exp_cmd.pop_front();
                        chk("cmd", 80'(got), 80'(e));
                    end
                end
                if (m_rdv[0]) begin
                    if (exp_rd0.size() == 0) begin
                        total++; bad++;
                        $display("FAIL m0_rdv_unexpected: actual=%h required=none", m_rdata[0]);
                    end else begin
                        er = exp_rd0.pop_front();
                        chk("m0_rdata", 80'(m_rdata[0]), 80'(er));
                    end
                end
                if (m_rdv[1]) begin
                    if (exp_rd1.size() == 0) begin
                        total++; bad++;
                        $display("FAIL m1_rdv_unexpected: actual=%h required=none", m_rdata[1]);
                    end else begin
                        er = exp_rd1.pop_front();
                        chk("m1_rdata", 80'(m_rdata[1]), 80'(er));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        m_addr = '0; m_rd = '0; m_wr = '0; m_bc = '0; m_wd = '0; m_be = '0;
        av_readdata = '0; av_readdatavalid = 1'b0;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_wait", 80'(m_wait), 80'(2'b11));
        chk("rst_av_rw", 80'({av_read, av_write}), 80'(2'b00));
        chk("rst_orphan", 80'(rd_orphan), 80'(0));
        chk("rst_rdv", 80'(m_rdv), 80'(2'b00));
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Round robin: alternating single-beat reads
        exp_r(32'h100, 8'd1); exp_r(32'h200, 8'd1);
        exp_r(32'h104, 8'd1); exp_r(32'h204, 8'd1);
        fork
            begin mrd(0, 32'h100, 8'd1); mrd(0, 32'h104, 8'd1); end
            begin mrd(1, 32'h200, 8'd1); mrd(1, 32'h204, 8'd1); end
        join
        exp_rd0.push_back(32'hA0); exp_rd1.push_back(32'hA1);
        exp_rd0.push_back(32'hA2); exp_rd1.push_back(32'hA3);
        ret(4, 32'hA0);

        // Write-burst lock with toggling waitrequest
        ws_mode = 1;
        for (int i = 0; i < 8; i++) exp_w(32'h1000, 8'd8, 4'hF, 32'hB000 + 32'(i));
        exp_r(32'h300, 8'd1);
        fork
            mwr(0, 32'h1000, 8'd8, 4'hF, 32'hB000);
            begin repeat (4) @(posedge clk); #1; mrd(1, 32'h300, 8'd1); end
        join
        ws_mode = 0;
        exp_rd1.push_back(32'hC0);
        ret(1, 32'hC0);
        @(posedge clk); #1;

        // FIFO full: four outstanding bursts, fifth read stalls, write passes
        for (int i = 0; i < 4; i++) exp_r(32'h400 + 32'(16 * i), 8'd4);
        for (int i = 0; i < 4; i++) mrd(0, 32'h400 + 32'(16 * i), 8'd4);
        exp_w(32'h2000, 8'd2, 4'h3, 32'hD000);
        exp_w(32'h2000, 8'd2, 4'h3, 32'hD001);
        exp_r(32'h500, 8'd1);
        fork
            mrd(0, 32'h500, 8'd1);
            begin
                mwr(1, 32'h2000, 8'd2, 4'h3, 32'hD000);
                repeat (3) begin
                    @(negedge clk);
                    chk("full_stall_m0_wait", 80'(m_wait[0]), 80'(1));
                end
                @(posedge clk); #1;
                for (int i = 0; i < 4; i++) exp_rd0.push_back(32'hE000 + 32'(i));
                ret(4, 32'hE000);
            end
        join
        for (int i = 0; i < 13; i++) exp_rd0.push_back(32'hE004 + 32'(i));
        ret(13, 32'hE004);

        // Interleaved return overlapping a write grant
        exp_r(32'h600, 8'd3); exp_r(32'h700, 8'd2);
        mrd(0, 32'h600, 8'd3);
        mrd(1, 32'h700, 8'd2);
        for (int i = 0; i < 3; i++) exp_rd0.push_back(32'hF000 + 32'(i));
        for (int i = 3; i < 5; i++) exp_rd1.push_back(32'hF000 + 32'(i));
        exp_w(32'h3000, 8'd2, 4'hC, 32'h9000);
        exp_w(32'h3000, 8'd2, 4'hC, 32'h9001);
        fork
            ret(5, 32'hF000);
            mwr(0, 32'h3000, 8'd2, 4'hC, 32'h9000);
        join

        // burstcount 0 behaves as a single beat
        exp_w(32'h3100, 8'd1, 4'h1, 32'h7700);
        mwr(1, 32'h3100, 8'd0, 4'h1, 32'h7700);

        // Async reset mid-burst with a read outstanding, then orphan beats
        exp_r(32'h800, 8'd2);
        mrd(0, 32'h800, 8'd2);
        ws_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        m_addr[1] = 32'h3200; m_bc[1] = 8'd4; m_wd[1] = 32'h0; m_be[1] = 4'hF; m_wr[1] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_av_write", 80'(av_write), 80'(1));
        chk("pre_rst_m1_wait", 80'(m_wait[1]), 80'(1));
        #2 reset = 1'b1;
        #1;
        chk("midrst_wait", 80'(m_wait), 80'(2'b11));
        chk("midrst_av_rw", 80'({av_read, av_write}), 80'(2'b00));
        chk("midrst_orphan", 80'(rd_orphan), 80'(0));
        m_wr[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        ws_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            av_readdatavalid = 1'b1;
            av_readdata      = 32'h5500 + 32'(i);
            @(negedge clk);
            chk("orphan_rdv", 80'(m_rdv), 80'(2'b00));
            @(posedge clk); #1;
        end
        av_readdatavalid = 1'b0;
        @(negedge clk);
        chk("orphan_set", 80'(rd_orphan), 80'(1));
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("orphan_sticky", 80'(rd_orphan), 80'(1));

        chk("cmd_left", 80'(exp_cmd.size()), 80'(0));
        chk("rd0_left", 80'(exp_rd0.size()), 80'(0));
        chk("rd1_left", 80'(exp_rd1.size()), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
